// File: rtl/seven_seg_mux_driver.sv
`timescale 1ns / 1ps
`default_nettype none
// seven_seg_mux_driver: scanned common-anode 7-segment driver with guard blanking and
// frame-synchronous double buffering. Rev 1.0. Optional macro SEVEN_SEG_LZB_EN: leading-zero blanking.
module seven_seg_mux_driver #(
  parameter int NUM_DIGITS   = 3,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_load,
  input  logic                    i_blank,
  output logic [7:0]              o_seven_seg,
  output logic [NUM_DIGITS-1:0]   o_digit_en_n,
  output logic                    o_frame_done
);

  localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W  = 4 * NUM_DIGITS;

  localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0]     SLOT_GUARD = SLOT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIGIT0     = NUM_DIGITS'(1);

  logic [SLOT_W-1:0]     slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [VAL_W-1:0]      active_val_q, active_val_d;
  logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] en_n_q, en_n_d;
  logic                  frame_done_q, frame_done_d;

  logic                  slot_end;
  logic                  frame_end;
  logic [3:0]            nibble;
  logic                  digit_dp;
  logic                  digit_lz;

  function automatic logic [7:0] decode_hex(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0:    s = 8'h03;
      4'h1:    s = 8'h9F;
      4'h2:    s = 8'h25;
      4'h3:    s = 8'h0D;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h49;
      4'h6:    s = 8'h41;
      4'h7:    s = 8'h1F;
      4'h8:    s = 8'h01;
      4'h9:    s = 8'h19;
      4'hA:    s = 8'h11;
      4'hB:    s = 8'hC1;
      4'hC:    s = 8'h63;
      4'hD:    s = 8'h85;
      4'hE:    s = 8'h61;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  // Scan position and double-buffered data registers.
  always_comb begin
    slot_end   = (slot_cnt_q == SLOT_LAST);
    frame_end  = slot_end && (idx_q == IDX_LAST);
    slot_cnt_d = slot_end ? '0 : slot_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    shadow_val_d = i_load ? i_value : shadow_val_q;
    shadow_dp_d  = i_load ? i_dp : shadow_dp_q;

    // A load on the boundary edge reaches active directly through shadow_*_d.
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    if (frame_end) begin
      active_val_d = shadow_val_d;
      active_dp_d  = shadow_dp_d;
    end

    frame_done_d = frame_end;
  end

`ifdef SEVEN_SEG_LZB_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  lz_seen;

  always_comb begin
    lz_mask = '0;
    lz_seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      lz_seen    = lz_seen | (active_val_d[4*k +: 4] != 4'h0);
      lz_mask[k] = ~lz_seen;
    end
  end

  assign digit_lz = lz_mask[idx_d];
`else
  assign digit_lz = 1'b0;
`endif

  // Outputs are decoded from next-state scan position so the registers line up with it.
  always_comb begin
    nibble   = active_val_d[{idx_d, 2'b00} +: 4];
    digit_dp = active_dp_d[idx_d];
    seg_d    = 8'hFF;
    en_n_d   = '1;
    if (!i_blank && (slot_cnt_d >= SLOT_GUARD)) begin
      en_n_d = ~(DIGIT0 << idx_d);
      seg_d  = digit_lz ? 8'hFF : decode_hex(nibble);
      if (digit_dp) begin
        seg_d[0] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      seg_q        <= 8'hFF;
      en_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      seg_q        <= seg_d;
      en_n_q       <= en_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_seven_seg  = seg_q;
  assign o_digit_en_n = en_n_q;
  assign o_frame_done = frame_done_q;

endmodule
`default_nettype wire
